zap_writeback_exc: RTL and testbench
====================================

# zap_writeback_exc

Parametrised successor to the ZAP writeback stage. It sequences PC and CPSR, arbitrates register-file writes, and performs exception entry. Compared with the current stage it adds a selectable write-port count (1 or 2, with a multi-cycle FSM when only one port exists), a per-source exception acknowledge, and optional high vectors. It sits after the memory stage and drives an external register file plus the fetch-side PC.

## Interface
Parameters:
- FLAG_WDT, 32, CPSR width.
- PHY_REGS, 46, physical register count; index width IW = $clog2(PHY_REGS).
- WR_PORTS, 2, register-file write ports; legal values are 1 or 2.

Ports (all registered outputs change on `i_clk` only):
- i_clk  in  1  core clock.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  instruction at writeback is valid.
- i_code_stall  in  1  fetch stalled; redirects are shelved.
- i_clear_from_alu / i_clear_from_decode  in  1  redirect requests.
- i_pc_from_alu / i_pc_from_decode  in  32  redirect targets.
- i_exc  in  6  exception requests, bit0 highest priority: DABT, FIQ, IRQ, PABT, SWI, UND.
- i_exc_lr  in  32  return address to write into the banked R14.
- i_hivec  in  1  select high vector base.
- i_wr_index, i_wr_index_1  in  IW  ALU-side and memory-side destinations.
- i_wr_data, i_wr_data_1  in  32  write data for the two destinations.
- i_mem_load_ff  in  1  memory-side write is a load.
- i_flags  in  FLAG_WDT  new CPSR.
- i_copro_reg_en  in  1  coprocessor register write.
- i_copro_reg_wr_index  in  IW  coprocessor write index.
- i_copro_reg_wr_data  in  32  coprocessor write data.
- o_wen_a, o_wen_b  out  1  write enables; o_wen_b is tied 0 when WR_PORTS=1.
- o_wa_a, o_wa_b  out  IW  write addresses.
- o_wd_a, o_wd_b  out  32  write data.
- o_pc  out  32  pc_ff.
- o_pc_nxt  out  32  next PC, bit0 forced to 0.
- o_cpsr, o_cpsr_nxt  out  32  current and next CPSR.
- o_clear_from_writeback  out  1  flush request.
- o_stall_from_writeback  out  1  second write cycle in progress.
- o_shelve  out  1  a redirect is pending.
- o_exc_ack  out  6  one-hot, registered acknowledge of the exception taken.

## Operation
- **Reset values:**
  - pc_ff = vector base.
  - cpsr_ff = 32'h000000D3 (SVC, I=1, F=1, T=0).
  - o_exc_ack = 0, shelve = 0, FSM = IDLE.
  - All write enables 0.
- **Vector base:** 0, or 32'hFFFF0000 when high vectors are compiled in and i_hivec=1.
- **Vector offsets by source:** DABT 0x10, FIQ 0x1C, IRQ 0x18, PABT 0x0C, SWI 0x08, UND 0x04.
- **PC priority, lowest first:**
  1. Increment by +4, or +2 when T=1.
  2. Hold while i_code_stall.
  3. Apply a shelved target.
  4. Decode redirect.
  5. ALU redirect.
  6. Load to PC (i_mem_load_ff and i_wr_index_1 == ARCH_PC).
  7. Exception.
- **Redirect during i_code_stall:** the target is stored in the shelf, pc_ff holds, and o_shelve=1. A newer redirect overwrites the shelf. The shelf is applied in the first cycle with i_code_stall=0.
- **Exception entry** (any i_exc bit, lowest index wins):
  - o_clear_from_writeback=1.
  - cpsr_nxt mode = banked mode for the source; I=1; T=0; F=1 for FIQ only.
  - Writes: banked R14 ← i_exc_lr, banked SPSR ← cpsr_ff.
  - Any concurrent i_valid or copro write is dropped.
- **Write priority:** exception > copro > valid. Copro wins over valid; the valid write is dropped.
- **Valid write:** cpsr_nxt = i_flags; port A ← (i_wr_index, i_wr_data); port B ← (i_wr_index_1, i_wr_data_1) only when i_mem_load_ff, otherwise PHY_RAZ_REGISTER.
- **FSM** (used only when WR_PORTS=1; with WR_PORTS=2 it stays in IDLE):
  - IDLE: issues the first write. Moves to EXC2 after an exception, or to LD2 after a valid load.
  - EXC2: writes SPSR and asserts o_stall_from_writeback. Returns to IDLE.
  - LD2: writes the load result and asserts o_stall_from_writeback. Returns to IDLE.
  - In EXC2 or LD2, new i_exc, i_valid and copro inputs are ignored. Upstream is stalled or flushed.
  - A load to PC in LD2 raises o_clear_from_writeback in the LD2 cycle.

## Timing
- Register-file write ports are combinational from the current inputs and the FSM state. The data is committed at the next edge.
- o_pc_nxt and o_cpsr_nxt are combinational. o_pc and o_cpsr take those values one cycle later.
- o_exc_ack is high for exactly one cycle, the cycle after the exception is taken.
- Exception → vector fetch:
  - 1 cycle with no code stall.
  - Otherwise, 1 cycle after i_code_stall falls.
- Reset asserted mid-FSM forces IDLE. A pending second write is discarded.

## Configuration
- ZAP_WB_HIGH_VECTORS_EN defined: i_hivec selects base 32'hFFFF0000, sampled each cycle. This also applies to the reset PC.
- Not defined: base is fixed at 0 and i_hivec is ignored.

## Structure
- **Shared package (zap_wb_pkg):**
  - FSM state enum {IDLE, EXC2, LD2}.
  - Vector offset table.
  - Per-source mode, R14 and SPSR physical indices, taken from the existing localparams (PHY_*_R14, PHY_*_SPSR, ARCH_PC, PHY_RAZ_REGISTER).
- **Sub-module zap_wb_exc_prio:** a combinational 6-input fixed-priority encoder producing a one-hot grant and a source index.

## Test plan
- Reset, then 3 idle cycles with T=0 → o_pc goes 0, 4, 8; cpsr = 0xD3.
- ALU redirect to 0x100 while i_code_stall=1 for 3 cycles → o_shelve=1 and pc holds. On stall release, pc = 0x100 and o_shelve=0.
- i_exc = 6'b000110 (FIQ and IRQ) with i_valid=1:
  - FIQ is taken: pc = 0x1C, mode FIQ, F=1, o_exc_ack = 6'b000010.
  - The valid write is dropped.
- WR_PORTS=1, valid load to r3 = 0xDEAD with ALU write to r1:
  - Cycle 0 writes r1; cycle 1 writes r3 with o_stall_from_writeback=1.
- High vectors compiled in, i_hivec=1, SWI → pc = 0xFFFF0008 and SVC R14 = i_exc_lr.
- Reset asserted in EXC2 → next cycle FSM is IDLE, no SPSR write, pc = vector base.

Source files
------------

// File: rtl/zap_wb_pkg.sv
// zap_wb_pkg: shared FSM states, register map and per-source exception tables for the writeback stage.
package zap_wb_pkg;
  typedef enum logic [1:0] {IDLE, EXC2, LD2} state_t;
  localparam int ARCH_PC = 15;
  localparam int PHY_RAZ_REGISTER = 16;
  localparam int PHY_FIQ_R14 = 23;
  localparam int PHY_IRQ_R14 = 25;
  localparam int PHY_SVC_R14 = 27;
  localparam int PHY_UND_R14 = 29;
  localparam int PHY_ABT_R14 = 31;
  localparam int PHY_FIQ_SPSR = 32;
  localparam int PHY_IRQ_SPSR = 33;
  localparam int PHY_SVC_SPSR = 34;
  localparam int PHY_UND_SPSR = 35;
  localparam int PHY_ABT_SPSR = 36;
  localparam logic [4:0] MODE_FIQ = 5'h11;
  localparam logic [4:0] MODE_IRQ = 5'h12;
  localparam logic [4:0] MODE_SVC = 5'h13;
  localparam logic [4:0] MODE_ABT = 5'h17;
  localparam logic [4:0] MODE_UND = 5'h1B;
  localparam logic [31:0] HIGH_VEC_BASE = 32'hFFFF0000;
  localparam logic [31:0] RESET_CPSR = 32'h000000D3;
  localparam int T_BIT = 5;
  localparam int F_BIT = 6;
  localparam logic [2:0] SRC_FIQ = 3'd1;
  // Source index order: 0 DABT, 1 FIQ, 2 IRQ, 3 PABT, 4 SWI, 5 UND.
  function automatic logic [31:0] vec_off(input logic [2:0] s);
    case (s)
      3'd0: return 32'h10;
      3'd1: return 32'h1C;
      3'd2: return 32'h18;
      3'd3: return 32'h0C;
      3'd4: return 32'h08;
      default: return 32'h04;
    endcase
  endfunction
  function automatic logic [4:0] exc_mode(input logic [2:0] s);
    case (s)
      3'd0, 3'd3: return MODE_ABT;
      3'd1: return MODE_FIQ;
      3'd2: return MODE_IRQ;
      3'd4: return MODE_SVC;
      default: return MODE_UND;
    endcase
  endfunction
  function automatic int exc_r14(input logic [2:0] s);
    case (s)
      3'd0, 3'd3: return PHY_ABT_R14;
      3'd1: return PHY_FIQ_R14;
      3'd2: return PHY_IRQ_R14;
      3'd4: return PHY_SVC_R14;
      default: return PHY_UND_R14;
    endcase
  endfunction
  function automatic int exc_spsr(input logic [2:0] s);
    case (s)
      3'd0, 3'd3: return PHY_ABT_SPSR;
      3'd1: return PHY_FIQ_SPSR;
      3'd2: return PHY_IRQ_SPSR;
      3'd4: return PHY_SVC_SPSR;
      default: return PHY_UND_SPSR;
    endcase
  endfunction
endpackage

// File: rtl/zap_wb_exc_prio.sv
// zap_wb_exc_prio: fixed-priority encoder over six exception requests, bit0 wins.
module zap_wb_exc_prio (
  input  logic [5:0] i_req,
  output logic [5:0] o_grant,
  output logic [2:0] o_idx,
  output logic       o_any
);
  assign o_any = |i_req;
  always_comb begin
    o_grant = '0;
    o_idx = '0;
    for (int i = 5; i >= 0; i--) begin
      if (i_req[i]) begin
        o_grant = '0;
        o_grant[i] = 1'b1;
        o_idx = 3'(i);
      end
    end
  end
endmodule

// File: rtl/zap_writeback_exc.sv
// zap_writeback_exc: writeback stage - PC/CPSR sequencing, register-file write arbitration, exception entry.
// Optional feature macro ZAP_WB_HIGH_VECTORS_EN enables the i_hivec-selected high vector base.
module zap_writeback_exc
  import zap_wb_pkg::*;
#(
  parameter int FLAG_WDT = 32,
  parameter int PHY_REGS = 46,
  parameter int WR_PORTS = 2,
  localparam int IW = $clog2(PHY_REGS)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic                i_code_stall,
  input  logic                i_clear_from_alu,
  input  logic                i_clear_from_decode,
  input  logic [31:0]         i_pc_from_alu,
  input  logic [31:0]         i_pc_from_decode,
  input  logic [5:0]          i_exc,
  input  logic [31:0]         i_exc_lr,
  input  logic                i_hivec,
  input  logic [IW-1:0]       i_wr_index,
  input  logic [IW-1:0]       i_wr_index_1,
  input  logic [31:0]         i_wr_data,
  input  logic [31:0]         i_wr_data_1,
  input  logic                i_mem_load_ff,
  input  logic [FLAG_WDT-1:0] i_flags,
  input  logic                i_copro_reg_en,
  input  logic [IW-1:0]       i_copro_reg_wr_index,
  input  logic [31:0]         i_copro_reg_wr_data,
  output logic                o_wen_a,
  output logic                o_wen_b,
  output logic [IW-1:0]       o_wa_a,
  output logic [IW-1:0]       o_wa_b,
  output logic [31:0]         o_wd_a,
  output logic [31:0]         o_wd_b,
  output logic [31:0]         o_pc,
  output logic [31:0]         o_pc_nxt,
  output logic [31:0]         o_cpsr,
  output logic [31:0]         o_cpsr_nxt,
  output logic                o_clear_from_writeback,
  output logic                o_stall_from_writeback,
  output logic                o_shelve,
  output logic [5:0]          o_exc_ack
);
  state_t state, state_nxt;
  logic [5:0] grant;
  logic [2:0] src;
  logic exc_any, idle, exc_take, cop, val, ld_pc, redirect;
  logic [31:0] base, tgt, pc_raw;
  logic [31:0] pc_ff, cpsr_ff, shelf_ff, spsr_data_ff, ld_data_ff;
  logic [IW-1:0] spsr_idx_ff, ld_idx_ff;
  logic shelve_ff;
  logic [5:0] exc_ack_ff;
`ifdef ZAP_WB_HIGH_VECTORS_EN
  assign base = i_hivec ? HIGH_VEC_BASE : 32'h0;
`else
  logic unused_hivec;
  assign unused_hivec = i_hivec;
  assign base = 32'h0;
`endif
  zap_wb_exc_prio u_prio (.i_req(i_exc), .o_grant(grant), .o_idx(src), .o_any(exc_any));
  assign o_pc = pc_ff;
  assign o_cpsr = cpsr_ff;
  assign o_shelve = shelve_ff;
  assign o_exc_ack = exc_ack_ff;
  always_comb begin
    idle = state == IDLE;
    exc_take = idle && exc_any;
    cop = idle && !exc_any && i_copro_reg_en;
    val = idle && !exc_any && !i_copro_reg_en && i_valid;
    // With one write port the load result (and any PC load) lands in LD2 from the latched copy.
    ld_pc = (state == LD2) ? (ld_idx_ff == IW'(ARCH_PC))
          : (WR_PORTS == 2 && val && i_mem_load_ff && i_wr_index_1 == IW'(ARCH_PC));
    redirect = exc_take || ld_pc || i_clear_from_alu || i_clear_from_decode;
    tgt = exc_take ? base + vec_off(src)
        : ld_pc ? ((state == LD2) ? ld_data_ff : i_wr_data_1)
        : i_clear_from_alu ? i_pc_from_alu : i_pc_from_decode;
    pc_raw = (redirect && !i_code_stall) ? tgt
           : i_code_stall ? pc_ff
           : shelve_ff ? shelf_ff
           : pc_ff + (cpsr_ff[T_BIT] ? 32'd2 : 32'd4);
    o_pc_nxt = {pc_raw[31:1], 1'b0};
    o_cpsr_nxt = exc_take ? {cpsr_ff[31:8], 1'b1, cpsr_ff[F_BIT] | (src == SRC_FIQ), 1'b0, exc_mode(src)}
               : val ? 32'(i_flags) : cpsr_ff;
    o_clear_from_writeback = exc_take || ld_pc;
    o_stall_from_writeback = !idle;
    o_wen_a = 1'b0;
    o_wa_a = '0;
    o_wd_a = '0;
    o_wen_b = 1'b0;
    o_wa_b = '0;
    o_wd_b = '0;
    state_nxt = IDLE;
    if (state == EXC2) begin
      o_wen_a = 1'b1;
      o_wa_a = spsr_idx_ff;
      o_wd_a = spsr_data_ff;
    end else if (state == LD2) begin
      o_wen_a = 1'b1;
      o_wa_a = ld_idx_ff;
      o_wd_a = ld_data_ff;
    end else if (exc_take) begin
      o_wen_a = 1'b1;
      o_wa_a = IW'(exc_r14(src));
      o_wd_a = i_exc_lr;
      if (WR_PORTS == 2) begin
        o_wen_b = 1'b1;
        o_wa_b = IW'(exc_spsr(src));
        o_wd_b = cpsr_ff;
      end else state_nxt = EXC2;
    end else if (cop) begin
      o_wen_a = 1'b1;
      o_wa_a = i_copro_reg_wr_index;
      o_wd_a = i_copro_reg_wr_data;
    end else if (val) begin
      o_wen_a = 1'b1;
      o_wa_a = i_wr_index;
      o_wd_a = i_wr_data;
      if (WR_PORTS == 2) begin
        o_wen_b = 1'b1;
        o_wa_b = i_mem_load_ff ? i_wr_index_1 : IW'(PHY_RAZ_REGISTER);
        o_wd_b = i_mem_load_ff ? i_wr_data_1 : 32'h0;
      end else if (i_mem_load_ff) state_nxt = LD2;
    end
    if (i_reset) begin
      o_wen_a = 1'b0;
      o_wen_b = 1'b0;
      state_nxt = IDLE;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_ff <= base;
      cpsr_ff <= RESET_CPSR;
      shelve_ff <= 1'b0;
      shelf_ff <= '0;
      exc_ack_ff <= '0;
      spsr_idx_ff <= '0;
      spsr_data_ff <= '0;
      ld_idx_ff <= '0;
      ld_data_ff <= '0;
    end else begin
      pc_ff <= o_pc_nxt;
      cpsr_ff <= o_cpsr_nxt;
      exc_ack_ff <= exc_take ? grant : 6'b0;
      if (redirect && i_code_stall) begin
        shelf_ff <= tgt;
        shelve_ff <= 1'b1;
      end else if (!i_code_stall) shelve_ff <= 1'b0;
      if (exc_take) begin
        spsr_idx_ff <= IW'(exc_spsr(src));
        spsr_data_ff <= cpsr_ff;
      end
      if (val) begin
        ld_idx_ff <= i_wr_index_1;
        ld_data_ff <= i_wr_data_1;
      end
    end
  end
endmodule

// File: tb/tb_zap_writeback_exc.sv
// tb_zap_writeback_exc: scoreboard bench driving a two-port and a one-port instance with shared stimulus.
module tb_zap_writeback_exc;
  localparam int IW = 6;
`ifdef ZAP_WB_HIGH_VECTORS_EN
  localparam logic [31:0] HV = 32'hFFFF0000;
`else
  localparam logic [31:0] HV = 32'h0;
`endif
  localparam int PC = 0, PCN = 1, CPSR = 2, CPSRN = 3, SHELVE = 4, ACK = 5, WEN_A = 6, WA_A = 7, WD_A = 8;
  localparam int WEN_B = 9, WA_B = 10, WD_B = 11, CLEAR = 12, STALL = 13;
  localparam int PC1 = 20, WEN_A1 = 26, WA_A1 = 27, WD_A1 = 28, CLEAR1 = 32, STALL1 = 33;
  logic clk = 0;
  logic i_reset, i_valid, i_code_stall, i_clear_from_alu, i_clear_from_decode, i_hivec, i_mem_load_ff, i_copro_reg_en;
  logic [31:0] i_pc_from_alu, i_pc_from_decode, i_exc_lr, i_wr_data, i_wr_data_1, i_flags, i_copro_reg_wr_data;
  logic [5:0] i_exc;
  logic [IW-1:0] i_wr_index, i_wr_index_1, i_copro_reg_wr_index;
  logic o_wen_a, o_wen_b, o_clear, o_stall, o_shelve;
  logic [IW-1:0] o_wa_a, o_wa_b;
  logic [31:0] o_wd_a, o_wd_b, o_pc, o_pc_nxt, o_cpsr, o_cpsr_nxt;
  logic [5:0] o_exc_ack;
  logic wen_a1, wen_b1, clear1, stall1, shelve1;
  logic [IW-1:0] wa_a1, wa_b1;
  logic [31:0] wd_a1, wd_b1, pc1, pc_nxt1, cpsr1, cpsr_nxt1;
  logic [5:0] exc_ack1;
  typedef struct { int cyc; int sel; logic [31:0] val; string name; } exp_t;
  exp_t q[$];
  int cyc = 0, total = 0, bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  zap_writeback_exc #(.WR_PORTS(2)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_code_stall(i_code_stall),
    .i_clear_from_alu(i_clear_from_alu), .i_clear_from_decode(i_clear_from_decode),
    .i_pc_from_alu(i_pc_from_alu), .i_pc_from_decode(i_pc_from_decode), .i_exc(i_exc), .i_exc_lr(i_exc_lr),
    .i_hivec(i_hivec), .i_wr_index(i_wr_index), .i_wr_index_1(i_wr_index_1), .i_wr_data(i_wr_data),
    .i_wr_data_1(i_wr_data_1), .i_mem_load_ff(i_mem_load_ff), .i_flags(i_flags), .i_copro_reg_en(i_copro_reg_en),
    .i_copro_reg_wr_index(i_copro_reg_wr_index), .i_copro_reg_wr_data(i_copro_reg_wr_data),
    .o_wen_a(o_wen_a), .o_wen_b(o_wen_b), .o_wa_a(o_wa_a), .o_wa_b(o_wa_b), .o_wd_a(o_wd_a), .o_wd_b(o_wd_b),
    .o_pc(o_pc), .o_pc_nxt(o_pc_nxt), .o_cpsr(o_cpsr), .o_cpsr_nxt(o_cpsr_nxt),
    .o_clear_from_writeback(o_clear), .o_stall_from_writeback(o_stall), .o_shelve(o_shelve), .o_exc_ack(o_exc_ack)
  );
  zap_writeback_exc #(.WR_PORTS(1)) dut1 (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_code_stall(i_code_stall),
    .i_clear_from_alu(i_clear_from_alu), .i_clear_from_decode(i_clear_from_decode),
    .i_pc_from_alu(i_pc_from_alu), .i_pc_from_decode(i_pc_from_decode), .i_exc(i_exc), .i_exc_lr(i_exc_lr),
    .i_hivec(i_hivec), .i_wr_index(i_wr_index), .i_wr_index_1(i_wr_index_1), .i_wr_data(i_wr_data),
    .i_wr_data_1(i_wr_data_1), .i_mem_load_ff(i_mem_load_ff), .i_flags(i_flags), .i_copro_reg_en(i_copro_reg_en),
    .i_copro_reg_wr_index(i_copro_reg_wr_index), .i_copro_reg_wr_data(i_copro_reg_wr_data),
    .o_wen_a(wen_a1), .o_wen_b(wen_b1), .o_wa_a(wa_a1), .o_wa_b(wa_b1), .o_wd_a(wd_a1), .o_wd_b(wd_b1),
    .o_pc(pc1), .o_pc_nxt(pc_nxt1), .o_cpsr(cpsr1), .o_cpsr_nxt(cpsr_nxt1),
    .o_clear_from_writeback(clear1), .o_stall_from_writeback(stall1), .o_shelve(shelve1), .o_exc_ack(exc_ack1)
  );
  function automatic logic [31:0] probe(input int s);
    case (s)
      PC: return o_pc;
      PCN: return o_pc_nxt;
      CPSR: return o_cpsr;
      CPSRN: return o_cpsr_nxt;
      SHELVE: return 32'(o_shelve);
      ACK: return 32'(o_exc_ack);
      WEN_A: return 32'(o_wen_a);
      WA_A: return 32'(o_wa_a);
      WD_A: return o_wd_a;
      WEN_B: return 32'(o_wen_b);
      WA_B: return 32'(o_wa_b);
      WD_B: return o_wd_b;
      CLEAR: return 32'(o_clear);
      STALL: return 32'(o_stall);
      PC1: return pc1;
      WEN_A1: return 32'(wen_a1);
      WA_A1: return 32'(wa_a1);
      WD_A1: return wd_a1;
      CLEAR1: return 32'(clear1);
      STALL1: return 32'(stall1);
      default: return 32'hxxxxxxxx;
    endcase
  endfunction
  task automatic chk(input int s, input logic [31:0] v, input string n);
    q.push_back('{cyc, s, v, n});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    i_reset = 0; i_valid = 0; i_code_stall = 0; i_clear_from_alu = 0; i_clear_from_decode = 0; i_hivec = 0;
    i_mem_load_ff = 0; i_copro_reg_en = 0; i_pc_from_alu = 0; i_pc_from_decode = 0; i_exc_lr = 0;
    i_wr_data = 0; i_wr_data_1 = 0; i_flags = 0; i_copro_reg_wr_data = 0; i_exc = 0;
    i_wr_index = 0; i_wr_index_1 = 0; i_copro_reg_wr_index = 0;
  endtask
  // Monitor: compares every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] got;
      e = q.pop_front();
      got = probe(e.sel);
      total++;
      if (e.cyc != cyc || got !== e.val) begin
        bad++;
        $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, got, e.val, e.cyc);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    i_reset = 1; i_valid = 0; i_code_stall = 0; i_clear_from_alu = 0; i_clear_from_decode = 0; i_hivec = 0;
    i_mem_load_ff = 0; i_copro_reg_en = 0; i_pc_from_alu = 0; i_pc_from_decode = 0; i_exc_lr = 0;
    i_wr_data = 0; i_wr_data_1 = 0; i_flags = 0; i_copro_reg_wr_data = 0; i_exc = 0;
    i_wr_index = 0; i_wr_index_1 = 0; i_copro_reg_wr_index = 0;
    step(); i_reset = 1;
    chk(WEN_A, 0, "rst_wen_a"); chk(WEN_A1, 0, "rst_wen_a1");
    step(); i_reset = 1;
    chk(PC, 0, "rst_pc"); chk(CPSR, 32'hD3, "rst_cpsr"); chk(ACK, 0, "rst_ack"); chk(SHELVE, 0, "rst_shelve");
    step(); chk(PC, 32'h0, "seq_pc0");
    step(); chk(PC, 32'h4, "seq_pc4");
    step(); chk(PC, 32'h8, "seq_pc8"); chk(PCN, 32'hC, "seq_pcn"); chk(CPSR, 32'hD3, "seq_cpsr");
    for (int k = 0; k < 3; k++) begin
      step(); i_code_stall = 1; i_clear_from_alu = 1; i_pc_from_alu = 32'h100;
      chk(PC, 32'hC, "stall_hold");
      if (k > 0) chk(SHELVE, 1, "stall_shelve");
    end
    step(); chk(SHELVE, 1, "release_shelve"); chk(PCN, 32'h100, "release_pcn");
    step(); chk(PC, 32'h100, "shelf_pc"); chk(SHELVE, 0, "shelf_clear");
    step(); i_exc = 6'b000110; i_valid = 1; i_wr_index = 5; i_wr_data = 32'h55; i_flags = 32'hF0000010; i_exc_lr = 32'h1234;
    chk(PC, 32'h104, "exc_pc_before"); chk(CLEAR, 1, "exc_clear"); chk(PCN, 32'h1C, "exc_vec");
    chk(CPSRN, 32'hD1, "exc_cpsrn"); chk(WA_A, 23, "exc_r14_idx"); chk(WD_A, 32'h1234, "exc_r14_data");
    chk(WA_B, 32, "exc_spsr_idx"); chk(WD_B, 32'hD3, "exc_spsr_data"); chk(WA_A1, 23, "exc1_r14_idx"); chk(STALL1, 0, "exc1_nostall");
    step(); chk(PC, 32'h1C, "exc_pc"); chk(CPSR, 32'hD1, "exc_cpsr"); chk(ACK, 32'b000010, "exc_ack");
    chk(STALL1, 1, "exc2_stall"); chk(WA_A1, 32, "exc2_spsr_idx"); chk(WD_A1, 32'hD3, "exc2_spsr_data"); chk(WEN_A, 0, "exc_idle_wen");
    step(); chk(ACK, 0, "exc_ack_drop"); chk(PC, 32'h20, "exc_pc_inc"); chk(STALL1, 0, "exc2_done");
    step(); i_valid = 1; i_wr_index = 1; i_wr_data = 32'h11; i_mem_load_ff = 1; i_wr_index_1 = 3; i_wr_data_1 = 32'hDEAD; i_flags = 32'hD3;
    chk(PC, 32'h24, "ld_pc"); chk(WA_A1, 1, "ld1_alu_idx"); chk(WD_A1, 32'h11, "ld1_alu_data"); chk(STALL1, 0, "ld1_nostall");
    chk(WA_B, 3, "ld_b_idx"); chk(WD_B, 32'hDEAD, "ld_b_data"); chk(CPSRN, 32'hD3, "ld_cpsrn");
    step(); chk(WA_A1, 3, "ld2_idx"); chk(WD_A1, 32'hDEAD, "ld2_data"); chk(STALL1, 1, "ld2_stall"); chk(WEN_A, 0, "ld_idle_wen");
    chk(CPSR, 32'hD3, "ld_cpsr");
    step(); i_copro_reg_en = 1; i_copro_reg_wr_index = 7; i_copro_reg_wr_data = 32'h77; i_valid = 1; i_wr_index = 2; i_wr_data = 32'h22;
    chk(WA_A, 7, "copro_idx"); chk(WD_A, 32'h77, "copro_data"); chk(WEN_B, 0, "copro_no_b"); chk(WA_A1, 7, "copro1_idx");
    step(); i_valid = 1; i_wr_index = 2; i_wr_data = 32'h22; i_mem_load_ff = 1; i_wr_index_1 = 15; i_wr_data_1 = 32'h400; i_flags = 32'hD3;
    chk(CLEAR, 1, "ldpc_clear"); chk(PCN, 32'h400, "ldpc_pcn"); chk(CLEAR1, 0, "ldpc1_noclear");
    step(); chk(PC, 32'h400, "ldpc_pc"); chk(STALL1, 1, "ldpc1_stall"); chk(CLEAR1, 1, "ldpc1_clear"); chk(WA_A1, 15, "ldpc1_idx");
    step(); chk(PC1, 32'h400, "ldpc1_pc");
    step(); i_hivec = 1; i_exc = 6'b010000; i_exc_lr = 32'hABC;
    chk(PCN, HV + 32'h8, "swi_vec"); chk(WA_A, 27, "swi_r14_idx"); chk(WD_A, 32'hABC, "swi_r14_data");
    chk(WA_B, 34, "swi_spsr_idx"); chk(CPSRN, 32'hD3, "swi_cpsrn");
    step(); i_reset = 1; i_hivec = 1;
    chk(PC, HV + 32'h8, "swi_pc"); chk(ACK, 32'b010000, "swi_ack"); chk(WEN_A1, 0, "rst_exc2_nowrite");
    step(); i_hivec = 1;
    chk(PC, HV, "rst_vec_pc"); chk(PC1, HV, "rst_vec_pc1"); chk(STALL1, 0, "rst_fsm_idle"); chk(WEN_A1, 0, "rst_idle_wen");
    chk(ACK, 0, "rst_ack2");
    step();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      bad += q.size();
      $display("FAIL scoreboard: %0d expectations unchecked, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
